// File: rtl/sequential_divider.sv
// Unsigned restoring divider: one quotient bit per clock behind a start/ready/valid
// handshake. A zero divisor is answered in a single cycle with a flag.
module sequential_divider #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  ready,
    output logic                  busy,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam int N  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t          state_q;
    logic [N-1:0]    divisor_q;
    logic [N-1:0]    rem_q;
    logic [N-1:0]    shift_q;
    logic [CW-1:0]   count_q;
    logic [N-1:0]    quotient_q;
    logic [N-1:0]    remainder_q;
    logic            busy_q;
    logic            ready_q;
    logic            valid_q;
    logic            dbz_q;

    logic [N:0]      trial_s;
    logic            fits_s;
    logic [N-1:0]    rem_d;
    logic [N-1:0]    shift_d;

    // One restoring step; the difference always fits N bits, so it is taken modulo 2^N.
    always_comb begin
        trial_s = {rem_q, shift_q[N-1]};
        fits_s  = (trial_s >= {1'b0, divisor_q});
        if (fits_s) begin
            rem_d = trial_s[N-1:0] - divisor_q;
        end else begin
            rem_d = trial_s[N-1:0];
        end
        shift_d = {shift_q[N-2:0], fits_s};
    end

    // Control FSM with datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            divisor_q   <= {N{1'b0}};
            rem_q       <= {N{1'b0}};
            shift_q     <= {N{1'b0}};
            count_q     <= {CW{1'b0}};
            quotient_q  <= {N{1'b0}};
            remainder_q <= {N{1'b0}};
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (divisor == {N{1'b0}}) begin
                            quotient_q  <= {N{1'b1}};
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            valid_q     <= 1'b1;
                        end else begin
                            divisor_q <= divisor;
                            rem_q     <= {N{1'b0}};
                            shift_q   <= dividend;
                            count_q   <= CW'(N);
                            busy_q    <= 1'b1;
                            ready_q   <= 1'b0;
                            state_q   <= CALC;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    rem_q   <= rem_d;
                    shift_q <= shift_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        quotient_q  <= shift_d;
                        remainder_q <= rem_d;
                        dbz_q       <= 1'b0;
                        valid_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= CALC;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready       = ready_q;
    assign busy        = busy_q;
    assign valid       = valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed and exhaustive bench for sequential_divider (DATA_WIDTH=4) with an
// expected-result queue drained by a valid monitor.
module tb_sequential_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       ready;
    logic       busy;
    logic       valid;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    sequential_divider #(.DATA_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .ready      (ready),
        .busy       (busy),
        .valid      (valid),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned q;
        int unsigned r;
        int unsigned dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge just before the accepting edge.
    task automatic push_exp(input int unsigned a, input int unsigned b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = 15; e.r = a; e.dz = 1; e.cyc = cyc + 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 0; e.cyc = cyc + 1 + 4;
        end
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (sb.size() > 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            check("result_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_op(input int unsigned a, input int unsigned b);
        dividend = 4'(a);
        divisor  = 4'(b);
        start    = 1'b1;
        push_exp(a, b);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", quotient, mon_e.q);
                check("remainder", remainder, mon_e.r);
                check("div_by_zero", div_by_zero, mon_e.dz);
                check("valid_cycle", cyc, mon_e.cyc);
                if (mon_e.dz == 0) begin
                    check("mul_check", quotient * mon_e.b + remainder, mon_e.a);
                    check("rem_lt_div", 32'(remainder < mon_e.b), 1);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        // 13/3: busy for four cycles then valid
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        push_exp(13, 3);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t1_busy", busy, 1);
            check("t1_ready", ready, 0);
            @(negedge clk);
        end
        check("t1_busy_done", busy, 0);
        check("t1_ready_done", ready, 1);
        wait_idle();
        @(negedge clk);

        // 7/0: one-cycle answer, busy never asserted
        dividend = 4'd7; divisor = 4'd0; start = 1'b1;
        push_exp(7, 0);
        @(negedge clk);
        start = 1'b0;
        check("t2_busy", busy, 0);
        check("t2_ready", ready, 1);
        @(negedge clk);
        check("t2_valid_pulse", valid, 0);
        wait_idle();

        // boundary operands
        do_op(3, 5);
        do_op(15, 1);
        do_op(0, 9);
        do_op(15, 15);

        // start while busy is ignored; captured operands survive input changes
        dividend = 4'd12; divisor = 4'd5; start = 1'b1;
        push_exp(12, 5);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = 4'd9; divisor = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dividend = 4'd1; divisor = 4'd1;
        wait_idle();
        repeat (3) @(negedge clk);
        check("t4_hold_q", quotient, 2);
        check("t4_hold_r", remainder, 2);
        check("t4_no_valid", valid, 0);

        // reset mid-operation after a div-by-zero result is on the outputs
        do_op(9, 0);
        dividend = 4'd14; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_q_zero", quotient, 0);
        check("t5_r_zero", remainder, 0);
        check("t5_dbz_zero", div_by_zero, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", ready, 1);
        check("t5_valid", valid, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        do_op(14, 3);

        // exhaustive, start held high back-to-back
        start = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                dividend = 4'(a);
                divisor  = 4'(b);
                push_exp(a, b);
                repeat ((b == 0) ? 1 : 5) @(negedge clk);
            end
        end
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("final_queue_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
